pll_lock_reset_sequencer: RTL
=============================

Name: pll_lock_reset_sequencer

Overview:
- Supervises the 50 MHz→100 MHz system PLL. Clocked by the free-running reference clock, so it is upstream of the PLL and also consumes its lock output.
- Drives the PLL reset pulse, synchronises and debounces `locked`, and releases the system reset only after lock has been stable.
- Retries PLL reset on lock timeout, re-asserts system reset on loss of lock, and exposes status and counters to the HPS/CSR layer.

Parameters:
- SYNC_STAGES, 2, flops in the `locked` synchroniser (min 2)
- PLL_RST_CYCLES, 16, refclk cycles `pll_rst` is held high per attempt (≥1)
- LOCK_TIMEOUT, 4096, refclk cycles allowed in WAIT_LOCK before retry
- STABLE_CYCLES, 1024, consecutive synchronised-locked cycles required before release
- MAX_RETRIES, 3, PLL reset retries after the initial attempt before FAIL
- CNT_W, 8, width of the status counters

Ports:
- refclk  in  1  reference clock, 50 MHz, free-running
- rst  in  1  asynchronous active-high reset
- locked  in  1  PLL lock, asynchronous to refclk
- pll_rst  out  1  reset to PLL; registered
- sys_rst  out  1  system reset request, active-high; registered; the consuming clock domain re-synchronises its deassertion
- ready  out  1  high only in RUN
- fail  out  1  high only in FAIL
- state  out  3  encoded FSM state: PLLRST=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4
- retry_cnt  out  CNT_W  PLL reset retries issued; saturating
- lock_loss_cnt  out  CNT_W  RUN→lock-loss events; saturating

Behaviour:
- Interface: one clock (refclk); reset `rst` is asynchronous and active-high.
- Reset values: state=PLLRST, pll_rst=1, sys_rst=1, ready=0, fail=0, counters=0, synchroniser=0, timers=0.
- All outputs are flops updated together with `state`. Output decode: pll_rst=(state==PLLRST); sys_rst=(state!=RUN); ready=(state==RUN); fail=(state==FAIL).
- `locked` passes through SYNC_STAGES flops to give locked_s. An edge on `locked` reaches locked_s SYNC_STAGES cycles later.
- One shared timer `tmr`, width clog2 of the largest of PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES. Cleared on every state transition.
- PLLRST: tmr increments. At tmr==PLL_RST_CYCLES-1 → WAIT_LOCK. Total pll_rst high time is exactly PLL_RST_CYCLES cycles.
- WAIT_LOCK:
  - locked_s=1 → STABLE.
  - Else at tmr==LOCK_TIMEOUT-1: if attempts < MAX_RETRIES → PLLRST and retry_cnt++. Else → FAIL.
  - If locked_s rises on the timeout cycle, lock wins.
- STABLE:
  - locked_s=0 → WAIT_LOCK. The timeout restarts; the attempt count is unchanged.
  - Else at tmr==STABLE_CYCLES-1 → RUN, so sys_rst deasserts on the next edge.
  - Release latency from the `locked` rise: SYNC_STAGES+1+STABLE_CYCLES cycles.
- RUN: locked_s=0 → WAIT_LOCK, lock_loss_cnt++, sys_rst=1 one cycle after locked_s falls. No PLL reset is issued; the PLL self-relocks. The attempt count clears on entry to RUN.
- FAIL: terminal until `rst`. pll_rst=0, sys_rst=1; `locked` is ignored.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Async `rst` mid-operation returns immediately to reset values, including the counters, and restarts with a fresh PLL reset pulse.
- A `locked` glitch shorter than one refclk cycle may or may not be captured. Either outcome is legal, but the FSM must not reach RUN unless locked_s was high for STABLE_CYCLES consecutive cycles.

Optional Feature:
- Macro PLL_SEQ_STATUS_CNT_EN.
- Defined: retry_cnt and lock_loss_cnt behave as above.
- Undefined: no counter flops are built, both ports are tied to 0, and the FSM is unaffected.

Decomposition:
- Package pll_seq_pkg: state enum and its encoding constants, plus a clog2 helper for timer width.
- One sub-module, `bit_sync` (parameter STAGES), holds the `locked` synchroniser so it can carry the CDC attribute. Everything else stays in the top.

Test Plan:
- Overrides for all scenarios: PLL_RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRIES=2.
- Nominal: release rst; assert locked at cycle 10 → pll_rst high exactly cycles 0–3; sys_rst falls 2+1+8=11 cycles after the locked rise; ready=1, state=3.
- Chatter: locked pulses high for 5 cycles, low for 1, then stays high → STABLE aborts to WAIT_LOCK; release occurs 11 cycles after the final rise; retry_cnt=0.
- Timeout retry/fail: locked held 0 → pll_rst pulses 3 times (4 cycles each, separated by 32-cycle waits); retry_cnt=2; then fail=1, state=4, pll_rst=0, sys_rst=1 permanently.
- Lock loss in RUN: drop locked for 20 cycles → sys_rst=1 3 cycles after the drop; lock_loss_cnt=1; no pll_rst pulse; re-release 11 cycles after relock.
- Saturation and reset: force 300 lock losses with CNT_W=8 → lock_loss_cnt=255. Then assert rst mid-STABLE → all outputs at reset values combinationally-asynchronously, counters=0.
- Macro off: repeat the timeout scenario → identical FSM timing; retry_cnt and lock_loss_cnt stay 0.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL lock/reset sequencer.
// Holds the FSM state encoding and the timer-width helpers.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    S_PLLRST = 3'd0,
    S_WAIT   = 3'd1,
    S_STABLE = 3'd2,
    S_RUN    = 3'd3,
    S_FAIL   = 3'd4
  } state_e;

  // Bits needed to count 0..v-1, never less than 1.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchroniser for a single asynchronous bit.
// Ports: clk, rst (async high), d_i (async in), q_o (synchronised out).
module bit_sync
  import pll_seq_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  (* ASYNC_REG = "TRUE" *)
  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_reset_sequencer.sv
// PLL supervisor: pulses pll_rst, debounces locked, gates sys_rst.
// Ports: refclk, rst, locked in; pll_rst, sys_rst, ready, fail,
// state, retry_cnt, lock_loss_cnt out (all registered).
// Macro PLL_SEQ_STATUS_CNT_EN builds the saturating status counters;
// without it both counter ports are tied to 0.
module pll_lock_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 4096,
  parameter int STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES    = 3,
  parameter int CNT_W          = 8
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             locked,
  output logic             pll_rst,
  output logic             sys_rst,
  output logic             ready,
  output logic             fail,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retry_cnt,
  output logic [CNT_W-1:0] lock_loss_cnt
);

  localparam int TMR_W = clog2(max3(PLL_RST_CYCLES,
                                    LOCK_TIMEOUT,
                                    STABLE_CYCLES));
  localparam int ATT_W = clog2(MAX_RETRIES + 1);

  localparam logic [TMR_W-1:0] PR_LAST =
    TMR_W'(PLL_RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] LT_LAST =
    TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] ST_LAST =
    TMR_W'(STABLE_CYCLES - 1);
  localparam logic [ATT_W-1:0] ATT_MAX =
    ATT_W'(MAX_RETRIES);

  logic             locked_s;
  state_e           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [ATT_W-1:0] att_q, att_d;
  logic             pll_rst_q, sys_rst_q;
  logic             ready_q, fail_q;
  logic             retry_inc, loss_inc;

  bit_sync #(
    .STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk(refclk),
    .rst(rst),
    .d_i(locked),
    .q_o(locked_s)
  );

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    att_d     = att_q;
    retry_inc = 1'b0;
    loss_inc  = 1'b0;
    unique case (state_q)
      S_PLLRST: begin
        tmr_d = tmr_q + TMR_W'(1);
        if (tmr_q == PR_LAST) state_d = S_WAIT;
      end
      S_WAIT: begin
        tmr_d = tmr_q + TMR_W'(1);
        // Lock wins over a coincident timeout.
        if (locked_s) begin
          state_d = S_STABLE;
        end else if (tmr_q == LT_LAST) begin
          if (att_q < ATT_MAX) begin
            state_d   = S_PLLRST;
            att_d     = att_q + ATT_W'(1);
            retry_inc = 1'b1;
          end else begin
            state_d = S_FAIL;
          end
        end
      end
      S_STABLE: begin
        tmr_d = tmr_q + TMR_W'(1);
        if (!locked_s) begin
          state_d = S_WAIT;
        end else if (tmr_q == ST_LAST) begin
          state_d = S_RUN;
          att_d   = '0;
        end
      end
      S_RUN: begin
        // The PLL relocks on its own; no new reset pulse.
        if (!locked_s) begin
          state_d  = S_WAIT;
          loss_inc = 1'b1;
        end
      end
      S_FAIL: ;
      default: state_d = S_PLLRST;
    endcase
    if (state_d != state_q) tmr_d = '0;
  end

  // Outputs decode the next state so they flip with state_q.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q   <= S_PLLRST;
      tmr_q     <= '0;
      att_q     <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      att_q     <= att_d;
      pll_rst_q <= (state_d == S_PLLRST);
      sys_rst_q <= (state_d != S_RUN);
      ready_q   <= (state_d == S_RUN);
      fail_q    <= (state_d == S_FAIL);
    end
  end

  assign pll_rst = pll_rst_q;
  assign sys_rst = sys_rst_q;
  assign ready   = ready_q;
  assign fail    = fail_q;
  assign state   = state_q;

`ifdef PLL_SEQ_STATUS_CNT_EN
  logic [CNT_W-1:0] retry_q, loss_q;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      retry_q <= '0;
      loss_q  <= '0;
    end else begin
      if (retry_inc && retry_q != '1)
        retry_q <= retry_q + CNT_W'(1);
      if (loss_inc && loss_q != '1)
        loss_q <= loss_q + CNT_W'(1);
    end
  end

  assign retry_cnt     = retry_q;
  assign lock_loss_cnt = loss_q;
`else
  logic unused_inc;
  assign unused_inc    = retry_inc ^ loss_inc;
  assign retry_cnt     = '0;
  assign lock_loss_cnt = '0;
`endif

endmodule
